dmem_arbiter: RTL and testbench

Two-requester arbiter that shares the single data-memory port between the pipeline's memory stage (CPU) and a DMA/loader master. The CPU has priority, but a starvation counter guarantees DMA service. Accesses complete in the granted cycle; a losing CPU request stalls the pipeline. The block sits between `riscv` (M-stage signals) and `dmem`, with the DMA master attached on the second port.

---
 rtl/dmem_arbiter.sv | 120 ++++++++++++
 tb/tb_dmem_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Shares the single data-memory port between the CPU M-stage and a DMA/loader
// master. The CPU wins contended cycles until the DMA master has been denied
// MAX_WAIT consecutive cycles; after that the DMA master wins the next
// contended cycle. Every access completes in the cycle it is granted.
//
// Handshake: a requester presents req plus stable fields; the access happens
// in the cycle its grant is high (cpu: ~cpu_stall, dma: dma_gnt). The DMA
// master holds dma_req and its fields until dma_gnt = 1 and may change them
// in the following cycle. The CPU holds its request while cpu_stall = 1.
//
// Ports:
//   clk, reset (async, active-low)
//   cpu_req/we/size/addr/wdata  CPU M-stage access
//   cpu_rdata                   combinational load data in the CPU grant cycle, else 0
//   cpu_stall                   cpu_req & ~cpu grant
//   dma_req/we/size/addr/wdata  DMA access, held until granted
//   dma_gnt                     DMA access performed this cycle
//   dma_rdata, dma_rvalid       registered DMA load data, valid one cycle after grant
//   mem_we/size/a/wd, mem_rd    dmem port
//   waitCnt                     debug view of the consecutive-denial counter
module dmem_arbiter #(
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [2:0]        cpu_size,
  input  logic [DATA_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [2:0]        dma_size,
  input  logic [DATA_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_rvalid,
  output logic              mem_we,
  output logic [2:0]        mem_size,
  output logic [DATA_W-1:0] mem_a,
  output logic [DATA_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_rd,
  output logic [3:0]        waitCnt
);

  localparam logic [3:0] MaxWait = 4'(MAX_WAIT);

  logic [3:0] waitCntQ;
  logic [3:0] waitCntNext;
  logic       cpuGnt;
  logic       dmaGnt;

  // Grant decision. Everything is forced off while reset is low so that no
  // store can reach dmem during reset, whatever the requesters are doing.
  always_comb begin
    cpuGnt = 1'b0;
    dmaGnt = 1'b0;
    if (reset) begin
      if (cpu_req && dma_req) begin
        if (waitCntQ >= MaxWait) dmaGnt = 1'b1;
        else                     cpuGnt = 1'b1;
      end else if (cpu_req) begin
        cpuGnt = 1'b1;
      end else if (dma_req) begin
        dmaGnt = 1'b1;
      end
    end
  end

  // Counts consecutive denied DMA cycles, saturating at MAX_WAIT.
  always_comb begin
    waitCntNext = 4'd0;
    if (dma_req && !dmaGnt) begin
      if (waitCntQ < MaxWait) waitCntNext = waitCntQ + 4'd1;
      else                    waitCntNext = MaxWait;
    end
  end

  // Memory-port mux; idle port drives zeros so mem_we can never glitch a store.
  always_comb begin
    mem_we   = 1'b0;
    mem_size = 3'd0;
    mem_a    = '0;
    mem_wd   = '0;
    if (dmaGnt) begin
      mem_we   = dma_we;
      mem_size = dma_size;
      mem_a    = dma_addr;
      mem_wd   = dma_wdata;
    end else if (cpuGnt) begin
      mem_we   = cpu_we;
      mem_size = cpu_size;
      mem_a    = cpu_addr;
      mem_wd   = cpu_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      waitCntQ   <= 4'd0;
      dma_rdata  <= '0;
      dma_rvalid <= 1'b0;
    end else begin
      waitCntQ   <= waitCntNext;
      dma_rvalid <= dmaGnt && !dma_we;
      if (dmaGnt && !dma_we) dma_rdata <= mem_rd;
    end
  end

  assign cpu_rdata = cpuGnt ? mem_rd : '0;
  assign cpu_stall = reset && cpu_req && !cpuGnt;
  assign dma_gnt   = dmaGnt;
  assign waitCnt   = waitCntQ;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;
  localparam int DW = 32;
  localparam int MW = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic          cpu_req = 0, cpu_we = 0;
  logic [2:0]    cpu_size = 3'd2;
  logic [DW-1:0] cpu_addr = '0, cpu_wdata = '0;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_stall;
  logic          dma_req = 0, dma_we = 0;
  logic [2:0]    dma_size = 3'd2;
  logic [DW-1:0] dma_addr = '0, dma_wdata = '0;
  logic          dma_gnt;
  logic [DW-1:0] dma_rdata;
  logic          dma_rvalid;
  logic          mem_we;
  logic [2:0]    mem_size;
  logic [DW-1:0] mem_a, mem_wd, mem_rd;
  logic [3:0]    waitCnt;

  dmem_arbiter #(.DATA_W(DW), .MAX_WAIT(MW)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_size(cpu_size), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_size(dma_size), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid),
    .mem_we(mem_we), .mem_size(mem_size), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd),
    .waitCnt(waitCnt)
  );

  // ---------------- dmem attached to the DUT ----------------
  logic [DW-1:0] dmem [0:1023];
  int st200 = 0;
  assign mem_rd = dmem[mem_a[11:2]];
  always @(posedge clk) begin
    if (mem_we) begin
      dmem[mem_a[11:2]] <= mem_wd;
      if (mem_a == 32'h200) st200++;
    end
  end

  // ---------------- scoreboard counters ----------------
  int vectors = 0;
  int errors  = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Arbitration described as: DMA wins if alone, or if it has already been
  // refused MW times in a row; CPU wins whenever it asks and DMA does not win.
  int            mWait   = 0;
  logic          mRvalid = 1'b0;
  logic [DW-1:0] mRdata  = '0;
  logic [DW-1:0] refMem [0:1023];
  logic [DW-1:0] exp_q [$];   // DMA load data expected on the next rvalid

  function automatic bit expDma();
    return reset && dma_req && (!cpu_req || mWait >= MW);
  endfunction
  function automatic bit expCpu();
    return reset && cpu_req && !expDma();
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mWait = 0; mRvalid = 1'b0; mRdata = '0;
      exp_q.delete();
    end else begin
      bit d, c;
      d = expDma();
      c = expCpu();
      mRvalid = d && !dma_we;
      if (mRvalid) begin
        mRdata = refMem[dma_addr[11:2]];
        exp_q.push_back(mRdata);
      end
      if (d && dma_we)      refMem[dma_addr[11:2]] = dma_wdata;
      else if (c && cpu_we) refMem[cpu_addr[11:2]] = cpu_wdata;
      if (dma_req && !d) mWait = (mWait + 1 > MW) ? MW : mWait + 1;
      else               mWait = 0;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    bit ed, ec;
    logic [DW-1:0] q;
    ed = expDma();
    ec = expCpu();
    check("dma_gnt",   dma_gnt, ed);
    check("cpu_stall", cpu_stall, reset && cpu_req && !ec);
    check("mem_we",    mem_we,   ed ? dma_we   : ec ? cpu_we   : 1'b0);
    check("mem_size",  mem_size, ed ? dma_size : ec ? cpu_size : 3'd0);
    check("mem_a",     mem_a,    ed ? dma_addr : ec ? cpu_addr : '0);
    check("mem_wd",    mem_wd,   ed ? dma_wdata: ec ? cpu_wdata: '0);
    check("cpu_rdata", cpu_rdata, ec ? refMem[cpu_addr[11:2]] : '0);
    check("dma_rvalid", dma_rvalid, mRvalid);
    check("dma_rdata",  dma_rdata, mRdata);
    check("wait_cnt",   waitCnt, mWait);
    if (mRvalid && exp_q.size() > 0) begin
      q = exp_q.pop_front();
      check("dma_rdata_q", dma_rdata, q);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cpu(input logic req, input logic we, input logic [DW-1:0] a, input logic [DW-1:0] d);
    cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic drive_dma(input logic req, input logic we, input logic [DW-1:0] a, input logic [DW-1:0] d);
    dma_req = req; dma_we = we; dma_addr = a; dma_wdata = d;
  endtask

  // ---------------- directed stimulus ----------------
  logic [9:0] gVec, sVec;
  logic [3:0] w5;

  initial begin
    for (int i = 0; i < 1024; i++) begin
      dmem[i] = '0;
      refMem[i] = '0;
    end
    dmem[32'h100 >> 2]   = 32'hDEADBEEF;
    refMem[32'h100 >> 2] = 32'hDEADBEEF;

    // Reset held with both requesters active and a CPU store pending.
    drive_cpu(1, 1, 32'h400, 32'hA5);
    drive_dma(1, 0, 32'h100, 32'h0);
    @(negedge clk);
    @(negedge clk);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_dma_gnt", dma_gnt, 1'b0);
    check("rst_cpu_stall", cpu_stall, 1'b0);
    check("rst_dma_rvalid", dma_rvalid, 1'b0);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("rel_cpu_first", {cpu_stall, dma_gnt, mem_we}, 3'b001);

    // Solo CPU load.
    cyc();
    drive_dma(0, 0, 32'h0, 32'h0);
    drive_cpu(1, 0, 32'h100, 32'h0);
    @(negedge clk);
    check("cpu_load", cpu_rdata, 32'hDEADBEEF);
    check("cpu_load_stall", cpu_stall, 1'b0);

    // Solo DMA load.
    cyc();
    drive_cpu(0, 0, 32'h0, 32'h0);
    drive_dma(1, 0, 32'h100, 32'h0);
    @(negedge clk);
    check("dma_load_gnt", dma_gnt, 1'b1);
    cyc();
    drive_dma(0, 0, 32'h0, 32'h0);
    @(negedge clk);
    check("dma_load_rvalid", dma_rvalid, 1'b1);
    check("dma_load_data", dma_rdata, 32'hDEADBEEF);

    // Continuous contention: expect CPU x4 then DMA, repeating.
    cyc();
    drive_cpu(1, 0, 32'h100, 32'h0);
    drive_dma(1, 0, 32'h100, 32'h0);
    w5 = 4'hF;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      gVec[i] = dma_gnt;
      sVec[i] = cpu_stall;
      if (i == 5) w5 = waitCnt;
      if (i < 9) cyc();
    end
    check("starve_gnt", gVec, 10'b1000010000);
    check("starve_stall", sVec, 10'b1000010000);
    check("starve_wait_clr", w5, 4'd0);

    // Stalled CPU store: build up DMA priority, then store collides.
    cyc();
    drive_cpu(0, 0, 32'h0, 32'h0);
    drive_dma(0, 0, 32'h0, 32'h0);
    cyc();
    drive_cpu(1, 0, 32'h100, 32'h0);
    drive_dma(1, 0, 32'h100, 32'h0);
    for (int i = 0; i < 4; i++) cyc();
    drive_cpu(1, 1, 32'h200, 32'h55);
    @(negedge clk);
    check("st_stall", cpu_stall, 1'b1);
    check("st_no_we", mem_we, 1'b0);
    cyc();
    drive_dma(0, 0, 32'h0, 32'h0);
    @(negedge clk);
    check("st_we", mem_we, 1'b1);
    check("st_addr", mem_a, 32'h200);
    cyc();
    drive_cpu(0, 0, 32'h0, 32'h0);
    @(negedge clk);
    check("st_once", st200, 1);
    check("st_data", dmem[32'h200 >> 2], 32'h55);

    // DMA store then load of the same address.
    cyc();
    drive_dma(1, 1, 32'h300, 32'h1234);
    @(negedge clk);
    check("dst_gnt", dma_gnt, 1'b1);
    cyc();
    drive_dma(1, 0, 32'h300, 32'h0);
    @(negedge clk);
    check("dld_gnt", dma_gnt, 1'b1);
    check("dst_no_rvalid", dma_rvalid, 1'b0);
    cyc();
    drive_dma(0, 0, 32'h0, 32'h0);
    @(negedge clk);
    check("dld_rvalid", dma_rvalid, 1'b1);
    check("dld_data", dma_rdata, 32'h1234);
    cyc();
    @(negedge clk);
    check("dld_pulse", dma_rvalid, 1'b0);

    // Async reset between a DMA load grant and the next edge.
    cyc();
    drive_cpu(1, 0, 32'h100, 32'h0);
    drive_dma(1, 0, 32'h100, 32'h0);
    for (int i = 0; i < 4; i++) cyc();
    @(negedge clk);
    check("arst_gnt", dma_gnt, 1'b1);
    #2 reset = 1'b0;
    cyc();
    drive_cpu(0, 0, 32'h0, 32'h0);
    drive_dma(0, 0, 32'h0, 32'h0);
    @(negedge clk);
    check("arst_rvalid", dma_rvalid, 1'b0);
    cyc();
    reset = 1'b1;
    @(negedge clk);
    check("arst_rvalid_rel", dma_rvalid, 1'b0);
    check("arst_wait", waitCnt, 4'd0);
    cyc();
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
